// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO block.
package fifo_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 8;

    // Pointer width for a power-of-two depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Depth x Width register array with one synchronous write port and one registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = ptr_width(DEF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data holds its value whenever no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_top.sv
// Single-clock FIFO: pointer/count control and registered flags around fifo_mem.
module sync_fifo_top
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk_w,
    input  logic             rst_n,
    input  logic             clk_r,
    input  logic [WIDTH-1:0] data_in,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          we;
    logic          re;

    // clk_r exists only for port compatibility.
    logic unused_clk_r;
    assign unused_clk_r = clk_r;

    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign we = wr_en & (~full | rd_en);
    assign re = rd_en & ~empty;

    always_comb begin
        count_nxt = count;
        if (we && !re) begin
            count_nxt = count + CW'(1);
        end else if (re && !we) begin
            count_nxt = count - CW'(1);
        end
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk_w) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (we) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (re) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == CW'(0));
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk_w),
        .rst   (rst_n),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (re),
        .raddr (rd_ptr),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_sync_fifo_top.sv
// Directed and randomized checks of sync_fifo_top against a queue-based FIFO model.
module tb_sync_fifo_top;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 8;

    logic             clk_w = 1'b0;
    logic             rst_n = 1'b1;
    logic             clk_r = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc_n  = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_dout = '0;

    sync_fifo_top #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk_w    (clk_w),
        .rst_n    (rst_n),
        .clk_r    (clk_r),
        .data_in  (data_in),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk_w = ~clk_w;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc_n, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, then compare just after it.
    task automatic step(input logic r, input logic w, input logic rd, input logic [WIDTH-1:0] d);
        rst_n   = r;
        wr_en   = w;
        rd_en   = rd;
        data_in = d;
        @(posedge clk_w);
        cyc_n++;
        if (r) begin
            model_q.delete();
            exp_dout = '0;
        end else begin
            int unsigned sz;
            bit rd_ok;
            bit wr_ok;
            sz    = model_q.size();
            rd_ok = rd && (sz > 0);
            wr_ok = w && ((sz < DEPTH) || rd);
            if (rd_ok) begin
                exp_dout = model_q.pop_front();
            end
            if (wr_ok) begin
                model_q.push_back(d);
            end
        end
        #1;
        check("data_out", data_out, exp_dout);
        check("full", WIDTH'(full), WIDTH'(model_q.size() == DEPTH));
        check("empty", WIDTH'(empty), WIDTH'(model_q.size() == 0));
    endtask

    logic [WIDTH-1:0] fill_words [8] = '{
        32'h1234ABCD, 32'h14AC1268, 32'h4D4D4D67, 32'h8E7E6E5E,
        32'hEEE54678, 32'hAAAAA543, 32'hFFFFFFFA, 32'hCECECECE
    };
    logic [WIDTH-1:0] wrap_words [3] = '{32'hCAFEBABE, 32'hBABABABA, 32'h12345678};

    initial begin
        // Reset for three cycles.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
        check("reset_dout", data_out, '0);

        // Fill, then an overflow write that must be dropped.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, fill_words[i]);
        check("full_after_fill", WIDTH'(full), WIDTH'(1));
        step(1'b0, 1'b1, 1'b0, 32'hDEADBEEF);

        // Drain in order.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            check("drain_word", data_out, fill_words[i]);
        end

        // Underflow reads leave data_out untouched.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, '0);
        check("underflow_hold", data_out, 32'hCECECECE);

        // Pointer wrap.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, wrap_words[i]);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            check("wrap_word", data_out, wrap_words[i]);
        end

        // Simultaneous read and write while full.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, fill_words[i]);
        step(1'b0, 1'b1, 1'b1, 32'h5A5A5A5A);
        check("simul_oldest", data_out, fill_words[0]);
        check("simul_full", WIDTH'(full), WIDTH'(1));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, '0);
        check("simul_last", data_out, 32'h5A5A5A5A);

        // Simultaneous read and write while empty: write only, no fall-through.
        step(1'b0, 1'b1, 1'b1, 32'h0BADF00D);
        check("empty_rw_hold", data_out, 32'h5A5A5A5A);
        step(1'b0, 1'b0, 1'b1, '0);
        check("empty_rw_read", data_out, 32'h0BADF00D);

        // Mid-operation reset discards stored data.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, fill_words[i]);
        step(1'b1, 1'b0, 1'b0, '0);
        check("midrst_dout", data_out, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        check("midrst_read", data_out, '0);

        // Randomized traffic with varying write/read bias and rare resets.
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 300; i++) begin
                logic r, w, rd;
                r  = ($urandom_range(0, 99) == 0);
                w  = ($urandom_range(0, 3) < ((p == 0) ? 3 : (p == 1) ? 1 : 2));
                rd = ($urandom_range(0, 3) < ((p == 0) ? 1 : (p == 1) ? 3 : 2));
                step(r, w, rd, WIDTH'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
